// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op codes, FSM states and the conditional negate helper for the multiply/divide unit
package mdu_pkg;
  typedef enum logic [1:0] {MDU_MULT = 2'd0, MDU_MULTU = 2'd1, MDU_DIV = 2'd2, MDU_DIVU = 2'd3} mdu_op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_e;
  localparam int MDU_XW = 64;
  function automatic logic [MDU_XW-1:0] negate_if(input logic [MDU_XW-1:0] val, input logic cond);
    return cond ? -val : val;
  endfunction
endpackage

// File: rtl/mdu_if.sv
// mdu_if: operand/command/result bundle between the EX stage (master) and the multiply/divide unit (slave)
interface mdu_if #(parameter int WIDTH = 32) ();
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       op;
  logic             start;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  modport master (output A, B, op, start, mthi, mtlo, input busy, done, div_zero, HI, LO);
  modport slave  (input A, B, op, start, mthi, mtlo, output busy, done, div_zero, HI, LO);
endinterface

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle on unsigned operands
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result
);
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [WIDTH:0]   sum, shifted;
  logic [WIDTH+1:0] diff;
  always_comb begin
    sum     = {1'b0, hi_q} + {1'b0, {WIDTH{lo_q[0]}} & b_q};
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, b_q};
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    if (load) begin
      hi_d = '0;
      lo_d = a;
      b_d  = b;
    end else if (step && is_div) begin
      hi_d = diff[WIDTH+1] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], ~diff[WIDTH+1]};
    end else if (step) begin
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      b_q  <= b_d;
    end
  end
  assign result = {hi_q, lo_q};
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU with internal HI/LO, MTHI/MTLO, done pulse and sticky div_zero
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DIV0_FAST = 1
) (
  input logic clk,
  input logic rst_n,
  mdu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic               is_div_q, is_div_d, div0_q, div0_d, div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d, hi_q, hi_d, lo_q, lo_d;
  logic               busy, accept, op_div, b_zero, a_neg, b_neg, move_ok;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] res;
  logic [MDU_XW-1:0]  prod_fix, quo_fix, rem_fix;
  mdu_state_e         start_state;
  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .step   (state_q == CALC),
    .is_div (is_div_q),
    .a      (a_abs),
    .b      (b_abs),
    .result (res)
  );
  always_comb begin
    busy        = (state_q == CALC) || (state_q == FIX);
    accept      = bus.start && !busy;
    move_ok     = !bus.start && !busy;
    op_div      = bus.op[1];
    b_zero      = bus.B == '0;
    a_neg       = !bus.op[0] && bus.A[WIDTH-1];
    b_neg       = !bus.op[0] && bus.B[WIDTH-1];
    a_abs       = a_neg ? -bus.A : bus.A;
    b_abs       = b_neg ? -bus.B : bus.B;
    // results are left-aligned in the helper's width so its negation is exactly mod 2^k for the field
    prod_fix    = negate_if(MDU_XW'(res) << (MDU_XW - 2*WIDTH), neg_res_q);
    quo_fix     = negate_if(MDU_XW'(res[WIDTH-1:0]) << (MDU_XW - WIDTH), neg_res_q);
    rem_fix     = negate_if(MDU_XW'(res[2*WIDTH-1:WIDTH]) << (MDU_XW - WIDTH), neg_rem_q);
    start_state = (op_div && b_zero && DIV0_FAST != 0) ? FIX : CALC;
    state_d     = accept ? start_state :
                  state_q == CALC ? (cnt_q == CW'(WIDTH-1) ? FIX : CALC) :
                  state_q == FIX  ? DONE :
                  state_q == DONE ? IDLE : state_q;
    cnt_d       = accept ? '0 : state_q == CALC ? cnt_q + 1'b1 : cnt_q;
    neg_res_d   = accept ? a_neg ^ b_neg : neg_res_q;
    neg_rem_d   = accept ? a_neg : neg_rem_q;
    is_div_d    = accept ? op_div : is_div_q;
    div0_d      = accept ? op_div && b_zero : div0_q;
    div_zero_d  = accept ? op_div && b_zero : div_zero_q;
    a_raw_d     = accept ? bus.A : a_raw_q;
    hi_d        = state_q == FIX ? (div0_q ? a_raw_q : is_div_q ? rem_fix[MDU_XW-1 -: WIDTH] : prod_fix[MDU_XW-1 -: WIDTH]) :
                  (bus.mthi && move_ok) ? bus.A : hi_q;
    lo_d        = state_q == FIX ? (div0_q ? '1 : is_div_q ? quo_fix[MDU_XW-1 -: WIDTH] : prod_fix[MDU_XW-WIDTH-1 -: WIDTH]) :
                  (bus.mtlo && move_ok) ? bus.A : lo_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_div_q   <= 1'b0;
      div0_q     <= 1'b0;
      div_zero_q <= 1'b0;
      a_raw_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      is_div_q   <= is_div_d;
      div0_q     <= div0_d;
      div_zero_q <= div_zero_d;
      a_raw_q    <= a_raw_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end
  assign bus.busy     = busy;
  assign bus.done     = state_q == DONE;
  assign bus.div_zero = div_zero_q;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors with a queue scoreboard checked on every done pulse
module tb_mult_div_unit;
  import mdu_pkg::*;
  typedef struct packed {logic dz; logic [31:0] hi; logic [31:0] lo;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t e;
  mdu_if #(.WIDTH(32)) bus ();
  mult_div_unit #(.WIDTH(32), .DIV0_FAST(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("HI", 64'(bus.HI), 64'(e.hi));
        chk("LO", 64'(bus.LO), 64'(e.lo));
        chk("div_zero", 64'(bus.div_zero), 64'(e.dz));
      end
    end
  end
  task automatic wait_done(input string n, input int exp_lat, input int exp_busy);
    int lat, bn;
    lat = 1;
    bn  = bus.busy ? 1 : 0;
    while (!bus.done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (bus.busy) bn++;
    end
    chk({n, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({n, "_busy_cycles"}, 64'(bn), 64'(exp_busy));
  endtask
  task automatic run_op(input string n, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic mv, input logic [31:0] eh, input logic [31:0] el, input logic edz,
                        input int exp_lat, input int exp_busy);
    @(negedge clk);
    bus.op = o; bus.A = a; bus.B = b; bus.start = 1'b1; bus.mthi = mv; bus.mtlo = mv;
    sb.push_back('{dz: edz, hi: eh, lo: el});
    @(negedge clk);
    bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    bus.A = ~a; bus.B = ~b; bus.op = ~o;
    wait_done(n, exp_lat, exp_busy);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.A = '0; bus.B = '0; bus.op = '0; bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    #3 rst_n = 1'b0;
    #20;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_div_zero", 64'(bus.div_zero), 64'd0);
    chk("rst_HI", 64'(bus.HI), 64'd0);
    chk("rst_LO", 64'(bus.LO), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    run_op("multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 33);
    run_op("mult_neg", MDU_MULT, 32'hFFFFFFFD, 32'd7, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 33);
    run_op("mult_min", MDU_MULT, 32'h80000000, 32'd2, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b0, 34, 33);
    run_op("multu_shift", MDU_MULTU, 32'h12345678, 32'h10, 1'b0, 32'h00000001, 32'h23456780, 1'b0, 34, 33);
    run_op("div_neg", MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 33);
    run_op("div_negb", MDU_DIV, 32'd7, 32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34, 33);
    run_op("divu", MDU_DIVU, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0, 34, 33);
    run_op("divu_zero", MDU_DIVU, 32'd5, 32'd0, 1'b0, 32'd5, 32'hFFFFFFFF, 1'b1, 2, 1);
    repeat (3) @(negedge clk);
    chk("div_zero_sticky", 64'(bus.div_zero), 64'd1);
    run_op("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000, 1'b0, 34, 33);
    run_op("div_zero_raw", MDU_DIV, 32'hFFFFFFF9, 32'd0, 1'b0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 2, 1);
    @(negedge clk);
    bus.op = MDU_MULTU; bus.A = 32'd3; bus.B = 32'd5; bus.start = 1'b1;
    sb.push_back('{dz: 1'b0, hi: 32'd0, lo: 32'd15});
    @(negedge clk) bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.op = MDU_DIVU; bus.A = 32'hDEAD; bus.B = 32'd7; bus.start = 1'b1; bus.mthi = 1'b1; bus.mtlo = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    wait_done("ignore_busy", 29, 28);
    repeat (40) @(negedge clk);
    bus.A = 32'h1234; bus.mthi = 1'b1;
    @(negedge clk) bus.mthi = 1'b0;
    chk("mthi_HI", 64'(bus.HI), 64'h1234);
    chk("mthi_LO_kept", 64'(bus.LO), 64'd15);
    bus.A = 32'hABCD; bus.mtlo = 1'b1;
    @(negedge clk) bus.mtlo = 1'b0;
    chk("mtlo_LO", 64'(bus.LO), 64'hABCD);
    chk("mtlo_HI_kept", 64'(bus.HI), 64'h1234);
    run_op("start_beats_move", MDU_MULTU, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6, 1'b0, 34, 33);
    @(negedge clk);
    bus.op = MDU_MULTU; bus.A = 32'hFFFFFFFF; bus.B = 32'hFFFFFFFF; bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_abort_busy", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_HI", 64'(bus.HI), 64'd0);
    chk("abort_LO", 64'(bus.LO), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done_HI", 64'(bus.HI), 64'd0);
    run_op("after_reset", MDU_DIVU, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0, 34, 33);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
